// File: rtl/mul_result_fifo.sv
// mul_result_fifo: sits after the shift-add multiplier. It captures one product
// on each rising edge of the multiplier's rdy level and queues it in a small
// first-word-fall-through FIFO. The consumer reads it over a valid/ready
// handshake. Captures that arrive while the FIFO is full are dropped and
// counted.
module mul_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_in,
    input  logic [2*WIDTH-1:0]   product_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_data,
    output logic                 out_hi_nz,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          level,
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [2*WIDTH-1:0] r_mem    [DEPTH];
    logic               r_hi_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_level;
    logic               r_rdy_q;
    logic               r_overflow;
    logic [7:0]         r_drop_cnt;

    logic w_cap;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_full;
    logic w_empty;

    // Occupancy flags and the capture, pop, push and drop decisions.
    // While full, a capture is accepted only if a pop frees a slot in the same cycle.
    always_comb begin
        w_full  = (r_level == LVL_FULL);
        w_empty = (r_level == '0);
        w_cap   = rdy_in & ~r_rdy_q;
        w_pop   = ~w_empty & out_ready;
        w_push  = w_cap & (~w_full | w_pop);
        w_drop  = w_cap & w_full & ~w_pop;
    end

    // Storage write; contents are deliberately not reset, since only the pointers matter.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr]    <= product_in;
            r_hi_mem[r_wr_ptr] <= |product_in[2*WIDTH-1:WIDTH];
        end
    end

    // Edge detector, pointers, occupancy and drop bookkeeping.
    // The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy_q    <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_rdy_q <= rdy_in;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (w_pop && !w_push) r_level <= r_level - 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // First-word-fall-through head and status outputs.
    always_comb begin
        out_valid = ~w_empty;
        out_data  = r_mem[r_rd_ptr];
        out_hi_nz = r_hi_mem[r_rd_ptr];
        full      = w_full;
        empty     = w_empty;
        level     = r_level;
        overflow  = r_overflow;
        drop_cnt  = r_drop_cnt;
    end

endmodule

// File: tb/tb_mul_result_fifo.sv
// Directed bench for mul_result_fifo with default parameters (WIDTH=32, DEPTH=4).
module tb_mul_result_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_in;
    logic [63:0] product_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_hi_nz;
    logic        full;
    logic        empty;
    logic [2:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    mul_result_fifo #(.WIDTH(32), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .product_in(product_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_hi_nz(out_hi_nz), .full(full), .empty(empty), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Make one low-to-high transition of rdy_in carrying product v; the capture happens at the second edge.
    task automatic push_edge(input logic [63:0] v);
        rdy_in = 1'b0;
        tick();
        rdy_in     = 1'b1;
        product_in = v;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy_in = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        product_in = '0;
        do_reset();
        n_cmp++;
        if (empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 || level !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_flags: empty=%b full=%b valid=%b level=%0d, want 1 0 0 0", empty, full, out_valid, level);
        end
        n_cmp++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_drop: overflow=%b drop_cnt=%0d, want 0 0", overflow, drop_cnt);
        end
    endtask

    task automatic test_single();
        push_edge(64'h0000_0002_FFFF_FFFE);
        n_cmp++;
        if (out_valid !== 1'b1 || level !== 3'd1) begin
            n_bad++;
            $display("FAIL single_valid: valid=%b level=%0d, want 1 1", out_valid, level);
        end
        n_cmp++;
        if (out_data !== 64'h0000_0002_FFFF_FFFE || out_hi_nz !== 1'b1) begin
            n_bad++;
            $display("FAIL single_data: data=%h hi_nz=%b, want 00000002fffffffe 1", out_data, out_hi_nz);
        end
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (level !== 3'd1) begin
            n_bad++;
            $display("FAIL single_held: level=%0d, want 1", level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL single_drain: empty=%b, want 1", empty);
        end
    endtask

    task automatic test_order_wrap();
        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 1; v <= 4; v++) push_edge(64'(pass*4 + v));
            n_cmp++;
            if (full !== 1'b1 || level !== 3'd4) begin
                n_bad++;
                $display("FAIL order_full pass %0d: full=%b level=%0d, want 1 4", pass, full, level);
            end
            out_ready = 1'b1;
            for (int v = 1; v <= 4; v++) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 64'(pass*4 + v) || out_hi_nz !== 1'b0) begin
                    n_bad++;
                    $display("FAIL order_data pass %0d: valid=%b data=%0d hi_nz=%b, want 1 %0d 0",
                             pass, out_valid, out_data, out_hi_nz, pass*4 + v);
                end
                tick();
            end
            n_cmp++;
            if (empty !== 1'b1 || level !== 3'd0) begin
                n_bad++;
                $display("FAIL order_empty pass %0d: empty=%b level=%0d, want 1 0", pass, empty, level);
            end
            // Keep out_ready high while empty; the pointers must not move.
            tick();
            tick();
            out_ready = 1'b0;
            n_cmp++;
            if (empty !== 1'b1 || level !== 3'd0) begin
                n_bad++;
                $display("FAIL empty_ready pass %0d: empty=%b level=%0d, want 1 0", pass, empty, level);
            end
        end
    endtask

    task automatic test_drop();
        for (int v = 1; v <= 4; v++) push_edge(64'(v));
        push_edge(64'd9);
        push_edge(64'd10);
        n_cmp++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd2 || level !== 3'd4) begin
            n_bad++;
            $display("FAIL drop_cnt: overflow=%b drop_cnt=%0d level=%0d, want 1 2 4", overflow, drop_cnt, level);
        end
        out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            n_cmp++;
            if (out_data !== 64'(v)) begin
                n_bad++;
                $display("FAIL drop_data: data=%0d, want %0d", out_data, v);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_push_pop_full();
        logic [63:0] exp_seq [4];
        exp_seq[0] = 64'd2; exp_seq[1] = 64'd3; exp_seq[2] = 64'd4; exp_seq[3] = 64'd11;
        for (int v = 1; v <= 4; v++) push_edge(64'(v));
        rdy_in = 1'b0;
        tick();
        rdy_in     = 1'b1;
        product_in = 64'd11;
        out_ready  = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (level !== 3'd4 || drop_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL full_pushpop: level=%0d drop_cnt=%0d, want 4 2", level, drop_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_data !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL full_pushpop_data[%0d]: data=%0d, want %0d", i, out_data, exp_seq[i]);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        push_edge(64'd21);
        rdy_in = 1'b0;
        tick();
        rdy_in     = 1'b1;
        product_in = 64'hFFFF_FFFF_0000_0016;
        out_ready  = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || level !== 3'd1 || out_data !== 64'hFFFF_FFFF_0000_0016 || out_hi_nz !== 1'b1) begin
            n_bad++;
            $display("FAIL back_to_back: valid=%b level=%0d data=%h hi_nz=%b, want 1 1 ffffffff00000016 1",
                     out_valid, level, out_data, out_hi_nz);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int v = 1; v <= 4; v++) push_edge(64'(v));
        for (int i = 0; i < 300; i++) push_edge(64'(100 + i));
        n_cmp++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1 || level !== 3'd4) begin
            n_bad++;
            $display("FAIL saturation: drop_cnt=%0d overflow=%b level=%0d, want 255 1 4", drop_cnt, overflow, level);
        end
    endtask

    task automatic test_reset_mid();
        // Carries on from saturation: overflow=1, drop_cnt=255. Drain one entry to leave level=3.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (level !== 3'd3) begin
            n_bad++;
            $display("FAIL mid_level: level=%0d, want 3", level);
        end
        rdy_in     = 1'b1;
        product_in = 64'd77;
        rst        = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (level !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_reset: level=%0d empty=%b overflow=%b drop_cnt=%0d, want 0 1 0 0",
                     level, empty, overflow, drop_cnt);
        end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (level !== 3'd1 || out_data !== 64'd77) begin
            n_bad++;
            $display("FAIL mid_recapture: level=%0d data=%0d, want 1 77", level, out_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        rdy_in = 1'b0;
        out_ready = 1'b0;
        product_in = '0;
        test_reset();
        test_single();
        test_order_wrap();
        test_drop();
        test_push_pop_full();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_result_fifo.md
Name: mul_result_fifo

Overview:
- Downstream stage of the shift-add unsigned multiplier.
- Watches the multiplier control's rdy output and captures the 2*WIDTH-bit product register value once per completed multiplication.
- Buffers results in a small first-word-fall-through FIFO and presents them to the consumer over a valid/ready handshake.
- Flags results that overflow WIDTH bits, and counts results dropped while the FIFO is full.

Parameters:
- WIDTH, 32: multiplier operand width; product width is 2*WIDTH.
- DEPTH, 4: number of FIFO entries; must be a power of two and at least 2.
- AW, 2: pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- rdy_in  input  1  done level from the multiplier control; stays high after completion until that control is reset.
- product_in  input  2*WIDTH  product register value; valid in any cycle where rdy_in is high.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  2*WIDTH  head entry product.
- out_hi_nz  output  1  head entry has a non-zero upper WIDTH bits (32-bit truncation overflow).
- full  output  1  occupancy equals DEPTH.
- empty  output  1  occupancy equals 0.
- level  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a capture is dropped.
- drop_cnt  output  8  number of dropped captures; saturates at 255.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers and level go to 0; empty=1, full=0, out_valid=0.
  - overflow=0, drop_cnt=0, and the edge register rdy_q=0.
  - No capture or pop occurs in a reset cycle.
  - Memory contents are not reset.
- Capture event:
  - cap = rdy_in & ~rdy_q, evaluated while rst=0; rdy_q <= rdy_in every non-reset cycle.
  - Exactly one capture per low-to-high transition of rdy_in; a held-high rdy_in never re-captures.
  - If rdy_in=1 on the first cycle after reset, that cycle is a capture.
- Push: on cap, write product_in to mem[wr_ptr] together with a hi_nz bit (OR-reduction of product_in[2*WIDTH-1:WIDTH]), then wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop: when out_valid & out_ready, rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- FWFT outputs:
  - out_valid = ~empty.
  - out_data and out_hi_nz are driven combinationally from mem[rd_ptr].
  - Latency is 1 cycle: a capture at edge N makes out_valid high after edge N.
- out_data/out_hi_nz when empty: don't-care; the bench must not check them.
- Level: push only → +1; pop only → -1; both → unchanged.
- Full with a capture:
  - If a pop occurs in the same cycle, the push is accepted and level stays at DEPTH.
  - Otherwise the capture is dropped: memory and pointers are unchanged, overflow <= 1, and drop_cnt increments (held at 255 once saturated).
- Empty with out_ready=1: no pop, and the pointers do not move.
- Simultaneous push and pop when level=1: the new entry becomes head on the next cycle; out_valid stays 1.
- overflow and drop_cnt clear only on rst.
- Reset mid-stream discards all buffered entries.

Test Plan:
- Single result: rst 2 cycles; pulse rdy_in 0→1 with product_in=64'h0000_0002_FFFF_FFFE, then hold high for 10 cycles → exactly one entry; out_valid=1 the cycle after the edge; out_data=64'h0000_0002_FFFF_FFFE; out_hi_nz=1; level=1.
- Order and wrap:
  - Stimulus: out_ready=0; four rdy_in rising edges with products 1, 2, 3, 4 → full=1, level=4.
  - Then hold out_ready=1 → out_data sequence 1, 2, 3, 4 with out_hi_nz=0; then empty=1.
  - Repeat with 5..8 → same ordering after pointer wrap.
- Drop on full: with the FIFO full and out_ready=0, two further edges with products 9 and 10 → overflow=1, drop_cnt=2; drained data is still 1..4.
- Push and pop while full: with the FIFO full, a capture of 11 in the same cycle as out_ready=1 → level stays 4, drop_cnt unchanged, 11 is drained last.
- Saturation: 300 dropped captures → drop_cnt=255.
- Reset mid-stream: level=3, assert rst one cycle → level=0, empty=1, overflow=0, drop_cnt=0. A rdy_in that stays high across the reset cycle yields exactly one capture afterward.
